// File: rtl/aes_seq_pkg.sv
// Shared types for the AES block-chaining sequencer: FSM states, chaining mode and
// the per-block request captured at the input handshake.
package aes_seq_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        OUT  = 2'd3
    } seq_state_t;

    typedef enum logic {
        ECB = 1'b0,
        CBC = 1'b1
    } seq_mode_t;

    typedef struct packed {
        logic [AES_BLK_W-1:0] key;
        logic [AES_BLK_W-1:0] text;
        seq_mode_t            mode;
        logic                 last;
    } seq_req_t;

endpackage

// File: rtl/aes_cbc_seq.sv
// ECB/CBC chaining sequencer in front of a 128-bit AES encrypt core, one block in flight.
// Optional processed-block counter on blk_cnt when AES_SEQ_CNT_EN is defined.
module aes_cbc_seq
    import aes_seq_pkg::*;
#(
    parameter int BLK_W = AES_BLK_W,
    parameter int CNT_W = 16
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             cfg_mode,
    input  logic [BLK_W-1:0] cfg_key,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic             cfg_iv_ld,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_last,
    output logic             aes_ld,
    output logic [BLK_W-1:0] aes_key,
    output logic [BLK_W-1:0] aes_text_in,
    input  logic             aes_done,
    input  logic [BLK_W-1:0] aes_text_out,
    output logic             busy
`ifdef AES_SEQ_CNT_EN
    ,
    output logic [CNT_W-1:0] blk_cnt
`endif
);

    if (BLK_W != AES_BLK_W) begin : g_bad_blk_w
        $error("aes_cbc_seq: only 128-bit blocks are supported");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("aes_cbc_seq: CNT_W must be at least 1");
    end

    seq_state_t           state, state_nxt;
    seq_req_t             req;
    logic [BLK_W-1:0]     chain;
    logic [BLK_W-1:0]     res_q;
    logic                 iv_pend;
    logic                 in_hs, out_hs;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        aes_ld    = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                // An IV load owns the cycle so the chain register never sees two writers.
                in_ready = !cfg_iv_ld && !rst;
                if (in_valid && !cfg_iv_ld && !rst) state_nxt = LOAD;
            end
            LOAD: begin
                aes_ld    = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (aes_done) state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge mclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            req     <= '0;
            chain   <= '0;
            res_q   <= '0;
            iv_pend <= 1'b0;
        end else begin
            if (cfg_iv_ld && state != IDLE) iv_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (cfg_iv_ld) begin
                        chain <= cfg_iv;
                    end else if (in_hs) begin
                        req.key  <= cfg_key;
                        req.mode <= seq_mode_t'(cfg_mode);
                        req.last <= in_last;
                        req.text <= cfg_mode ? (in_data ^ chain) : in_data;
                    end
                end
                BUSY: begin
                    if (aes_done) begin
                        res_q <= aes_text_out;
                        if (req.mode == CBC) chain <= aes_text_out;
                    end
                end
                OUT: begin
                    // End of message or a deferred IV load restarts the chain from cfg_iv.
                    if (out_ready) begin
                        if (req.last || iv_pend || cfg_iv_ld) chain <= cfg_iv;
                        iv_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data    = res_q;
    assign out_last    = req.last;
    assign aes_key     = req.key;
    assign aes_text_in = req.text;
    assign busy        = (state != IDLE);

`ifdef AES_SEQ_CNT_EN
    always_ff @(posedge mclk) begin
        if (rst || cfg_iv_ld) blk_cnt <= '0;
        else if (out_hs)      blk_cnt <= blk_cnt + 1'b1;
    end
`else
    logic unused_out_hs;
    assign unused_out_hs = out_hs;
`endif

endmodule
